// File: rtl/k005297_trigger_bank.sv
// rtl/k005297_trigger_bank.sv - multi-channel step/phase compare trigger bank
// Optional address-reset strobe enabled by defining K005297_TRIGBANK_ADDR_RST_EN.
module k005297_trigger_bank #(
  parameter int CH     = 4,
  parameter int CNTW   = 10,
  parameter int PHASES = 20
) (
  input  logic                        i_MCLK,
  input  logic                        i_RST,
  input  logic                        i_CLK2M_PCEN_n,
  input  logic                        i_RUN,
  input  logic                        i_HALT,
  input  logic                        i_CYCLE_LSB,
  input  logic [CH*CNTW-1:0]          i_CMP_VAL,
  input  logic [CH-1:0]               i_CMP_PAR,
  input  logic [CH-1:0]               i_MODE,
  input  logic [CH-1:0]               i_CLR,
  output logic [CH-1:0]               o_TRIG,
  output logic [CNTW-1:0]             o_STEP,
  output logic [$clog2(PHASES)-1:0]   o_PHASE,
  output logic                        o_STEP_WRAP,
  output logic                        o_ADDR_RST
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_XFER = PW'(PHASES / 2);

  logic          ce;
  logic          qual;
  logic          at_last;
  logic          at_xfer;
  logic [CH-1:0] eq;
  logic [CH-1:0] eq_cmp;
  logic [CH-1:0] trig_next;

  assign ce      = ~i_CLK2M_PCEN_n;
  assign qual    = i_CYCLE_LSB | i_HALT;
  assign at_last = (o_PHASE == PH_LAST);
  assign at_xfer = (o_PHASE == PH_XFER);

  // Compare uses the step value before the end-of-step increment.
  always_comb begin
    eq_cmp = '0;
    for (int n = 0; n < CH; n++) begin
      eq_cmp[n] = (o_STEP == i_CMP_VAL[n*CNTW +: CNTW]) && (qual == i_CMP_PAR[n]);
    end
  end

  // Clear is applied last so it wins over a simultaneous transfer.
  always_comb begin
    trig_next = o_TRIG;
    if (i_RUN) begin
      if (at_xfer) begin
        for (int n = 0; n < CH; n++) begin
          trig_next[n] = i_MODE[n] ? eq[n] : (o_TRIG[n] | eq[n]);
        end
      end
    end else begin
      trig_next = o_TRIG & ~i_MODE;
    end
    trig_next = trig_next & ~i_CLR;
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      o_PHASE     <= '0;
      o_STEP      <= '0;
      eq          <= '0;
      o_TRIG      <= '0;
      o_STEP_WRAP <= 1'b0;
    end else begin
      o_STEP_WRAP <= 1'b0;
      if (ce) begin
        o_TRIG <= trig_next;
        if (!i_RUN) begin
          o_PHASE <= '0;
          o_STEP  <= '0;
          eq      <= '0;
        end else if (at_last) begin
          o_PHASE     <= '0;
          o_STEP      <= o_STEP + CNTW'(1);
          eq          <= eq_cmp;
          o_STEP_WRAP <= (o_STEP == {CNTW{1'b1}});
        end else begin
          o_PHASE <= o_PHASE + PW'(1);
        end
      end
    end
  end

`ifdef K005297_TRIGBANK_ADDR_RST_EN
  localparam logic [PW-1:0] PH_PRE = PW'(PHASES - 2);
  logic pre_flag;

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      pre_flag <= 1'b0;
    end else if (ce) begin
      pre_flag <= i_RUN && (o_PHASE == PH_PRE);
    end
  end

  assign o_ADDR_RST = o_TRIG[0] & pre_flag;
`else
  assign o_ADDR_RST = 1'b0;
`endif

endmodule

// File: tb/tb_k005297_trigger_bank.sv
// tb/tb_k005297_trigger_bank.sv - randomized bench with a step/phase arithmetic reference model
module tb_k005297_trigger_bank;
  localparam int CH = 4;
  localparam int CNTW = 10;
  localparam int PHASES = 20;
  localparam int PW = $clog2(PHASES);
  localparam int NSTEP = 1 << CNTW;

  logic               i_MCLK = 1'b0;
  logic               i_RST = 1'b1;
  logic               i_CLK2M_PCEN_n = 1'b0;
  logic               i_RUN = 1'b0;
  logic               i_HALT = 1'b0;
  logic               i_CYCLE_LSB = 1'b0;
  logic [CH*CNTW-1:0] i_CMP_VAL = '0;
  logic [CH-1:0]      i_CMP_PAR = '0;
  logic [CH-1:0]      i_MODE = '0;
  logic [CH-1:0]      i_CLR = '0;
  logic [CH-1:0]      o_TRIG;
  logic [CNTW-1:0]    o_STEP;
  logic [PW-1:0]      o_PHASE;
  logic               o_STEP_WRAP;
  logic               o_ADDR_RST;

  k005297_trigger_bank dut (
    .i_MCLK(i_MCLK), .i_RST(i_RST), .i_CLK2M_PCEN_n(i_CLK2M_PCEN_n),
    .i_RUN(i_RUN), .i_HALT(i_HALT), .i_CYCLE_LSB(i_CYCLE_LSB),
    .i_CMP_VAL(i_CMP_VAL), .i_CMP_PAR(i_CMP_PAR), .i_MODE(i_MODE), .i_CLR(i_CLR),
    .o_TRIG(o_TRIG), .o_STEP(o_STEP), .o_PHASE(o_PHASE),
    .o_STEP_WRAP(o_STEP_WRAP), .o_ADDR_RST(o_ADDR_RST)
  );

  always #5 i_MCLK = ~i_MCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cmp_v [CH];

  // Reference: m_cnt counts CEs since run start; phase/step derive from it arithmetically.
  int            m_cnt = 0;
  logic [CH-1:0] m_trig = '0;
  logic [CH-1:0] m_eq = '0;
  logic          m_wrap = 1'b0;
  logic          m_pre = 1'b0;
  bit            rand_clr2 = 1'b0;
  bit            rand_lsb = 1'b0;

  function automatic int m_phase();
    return m_cnt % PHASES;
  endfunction

  function automatic int m_step();
    return (m_cnt / PHASES) % NSTEP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmp(input int n, input int v);
    cmp_v[n] = v;
    i_CMP_VAL[n*CNTW +: CNTW] = CNTW'(v);
  endtask

  task automatic model_update();
    int ph;
    int st;
    m_wrap = 1'b0;
    if (i_RST) begin
      m_cnt = 0; m_trig = '0; m_eq = '0; m_pre = 1'b0;
    end else if (!i_CLK2M_PCEN_n) begin
      if (!i_RUN) begin
        m_cnt = 0; m_eq = '0; m_pre = 1'b0;
        m_trig = m_trig & ~i_MODE;
      end else begin
        ph = m_phase();
        st = m_step();
        if (ph == PHASES / 2)
          for (int n = 0; n < CH; n++)
            m_trig[n] = i_MODE[n] ? m_eq[n] : (m_trig[n] | m_eq[n]);
        if (ph == PHASES - 1)
          for (int n = 0; n < CH; n++)
            m_eq[n] = (st == cmp_v[n]) && ((i_CYCLE_LSB | i_HALT) == i_CMP_PAR[n]);
        m_wrap = (ph == PHASES - 1) && (st == NSTEP - 1);
        m_pre = (ph == PHASES - 2);
        m_cnt = (m_cnt + 1) % (PHASES * NSTEP);
      end
      m_trig = m_trig & ~i_CLR;
    end
  endtask

  task automatic tick();
    logic exp_ar;
    @(posedge i_MCLK);
    model_update();
    @(negedge i_MCLK);
`ifdef K005297_TRIGBANK_ADDR_RST_EN
    exp_ar = m_trig[0] & m_pre;
`else
    exp_ar = 1'b0;
`endif
    chk("trig", 32'(o_TRIG), 32'(m_trig));
    chk("step", 32'(o_STEP), m_step());
    chk("phase", 32'(o_PHASE), m_phase());
    chk("step_wrap", 32'(o_STEP_WRAP), 32'(m_wrap));
    chk("addr_rst", 32'(o_ADDR_RST), 32'(exp_ar));
  endtask

  task automatic rand_drive();
    i_CLK2M_PCEN_n = ($urandom_range(3) == 0);
    i_CLR = '0;
    if (rand_clr2) i_CLR[2] = ($urandom_range(299) == 0);
    if (rand_lsb) i_CYCLE_LSB = $urandom_range(1);
  endtask

  task automatic run_until(input string tag, input int target, input int bound);
    int k = 0;
    while (m_cnt != target && k < bound) begin
      rand_drive();
      tick();
      k++;
    end
    chk(tag, int'(o_STEP) * PHASES + int'(o_PHASE), target);
  endtask

  initial begin
    int cyc;
    int wraps;
    int first_rise;

    for (int n = 0; n < CH; n++) set_cmp(n, 0);
    i_RST = 1'b1;
    repeat (3) tick();
    chk("reset_trig", 32'(o_TRIG), 0);
    chk("reset_step", 32'(o_STEP), 0);

    // Full rotation: ch0 sticky 702, ch1 pulse 97, ch2 random sticky, ch3 shares 702.
    i_RST = 1'b0;
    i_RUN = 1'b1;
    set_cmp(0, 702);
    set_cmp(1, 97);
    set_cmp(2, $urandom_range(NSTEP - 1));
    set_cmp(3, 702);
    i_CMP_PAR = '0;
    i_MODE = 4'b0010;
    i_MODE[3] = $urandom_range(1);
    rand_clr2 = 1'b1;
    cyc = 0;
    wraps = 0;
    first_rise = -1;
    while (wraps == 0 && cyc < 32000) begin
      rand_drive();
      tick();
      if (first_rise < 0 && o_TRIG[0]) first_rise = int'(o_STEP) * PHASES + int'(o_PHASE);
      if (o_STEP_WRAP) begin
        wraps++;
        chk("trig0_held_at_wrap", 32'(o_TRIG[0]), 1);
      end
      cyc++;
    end
    chk("wrap_seen", wraps, 1);
    chk("trig0_rise_point", first_rise, 703 * PHASES + PHASES / 2 + 1);

    // Mid-count reset at step 500 phase 7 with CE active.
    rand_clr2 = 1'b0;
    run_until("reach_500_7", 500 * PHASES + 7, 20000);
    i_RST = 1'b1;
    i_CLK2M_PCEN_n = 1'b0;
    i_CLR = '0;
    tick();
    chk("rst_trig", 32'(o_TRIG), 0);
    chk("rst_step", 32'(o_STEP), 0);
    chk("rst_phase", 32'(o_PHASE), 0);
    i_RST = 1'b0;

    // Halt-forced parity, random LSB, then clear colliding with a transfer.
    i_HALT = 1'b1;
    rand_lsb = 1'b1;
    set_cmp(1, 1);
    set_cmp(2, 2);
    set_cmp(3, 1);
    i_CMP_PAR = 4'b0110;
    i_MODE = 4'b0010;
    run_until("reach_3_10", 3 * PHASES + 10, 400);
    rand_drive();
    i_CLK2M_PCEN_n = 1'b0;
    tick();
    chk("trig2_set", 32'(o_TRIG[2]), 1);
    set_cmp(2, 3);
    run_until("reach_4_10", 4 * PHASES + 10, 400);
    i_CLK2M_PCEN_n = 1'b0;
    i_CLR = 4'b0100;
    tick();
    chk("clr_beats_xfer", 32'(o_TRIG[2]), 0);
    i_CLR = '0;
    run_until("reach_6_5", 6 * PHASES + 5, 400);

    // Stop rotation: counters clear, pulse bits drop, sticky bits hold.
    i_RUN = 1'b0;
    repeat (30) begin rand_drive(); tick(); end
    i_RUN = 1'b1;
    repeat (200) begin rand_drive(); tick(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
